dct_block_sequencer: RTL and testbench
======================================

Name: dct_block_sequencer

Overview:
Clocked controller that feeds the combinational 8x8 DCT/quantise/zigzag datapath one block at a time.
- Input: a serial pixel stream (64 elements per block, row-major).
- Drives the datapath's 64-element `original` bus, waits a settle time, then captures the 32 zigzag coefficients.
- Output: the 32 coefficients as a serial stream under valid/ready.
- Replaces the #1-delay file loop with synthesizable sequencing for NUM_BLOCKS blocks per frame (256x256x3 image).

Parameters:
ELEM_W, 64, width of one pixel / coefficient element (matches datapath packing)
NUM_BLOCKS, 3072, 8x8 blocks per frame
SETTLE, 2, cycles between last pixel accepted and coefficient capture (datapath combinational depth budget; legal range 1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a frame when IDLE or DONE
abort  in  1  synchronous; returns to IDLE from any state next edge
pix_data  in  ELEM_W  pixel element, row-major within block
pix_valid  in  1  pix_data valid
pix_ready  out  1  sequencer accepts pixel
dp_original  out  64*ELEM_W  to datapath `original`; element i at [i*ELEM_W +: ELEM_W]
dp_coeff  in  32*ELEM_W  from datapath `C`; zigzag element l at [l*ELEM_W +: ELEM_W]
coeff_data  out  ELEM_W  coefficient element, signed
coeff_valid  out  1  coeff_data valid
coeff_ready  in  1  downstream accepts
coeff_last  out  1  high with the 32nd coefficient of a block
frame_last  out  1  high with the 32nd coefficient of block NUM_BLOCKS-1
block_cnt  out  12  index of the block in progress
busy  out  1  state not IDLE/DONE
done  out  1  frame complete; level, cleared by start/abort

Behaviour:
- Reset (async, rst=1): state=IDLE, dp_original=0, coefficient buffer=0, all counters 0.
  - Outputs at reset: pix_ready=0, coeff_valid=0, coeff_data=0, coeff_last=0, frame_last=0, busy=0, done=0, block_cnt=0.
  - rst mid-block discards all partial data; no output handshake completes on that edge.
- States: IDLE, LOAD, SETTLE, DRAIN, DONE.
- IDLE:
  - pix_ready=0.
  - start -> LOAD; block_cnt=0, elem_cnt=0.
  - start is ignored in LOAD/SETTLE/DRAIN.
- LOAD:
  - pix_ready=1.
  - Each pix_valid&pix_ready writes dp_original[elem_cnt] and increments elem_cnt (6 bits).
  - The accept with elem_cnt==63 -> SETTLE, settle_cnt=0.
  - Elements not yet rewritten hold the previous block's values.
- SETTLE:
  - pix_ready=0; dp_original stable.
  - Counts SETTLE cycles. In the last one, capture all 32 dp_coeff elements into the internal buffer -> DRAIN, out_idx=0.
- DRAIN:
  - coeff_valid=1; coeff_data=buf[out_idx]; coeff_last=(out_idx==31); frame_last=coeff_last&(block_cnt==NUM_BLOCKS-1).
  - Held stable while coeff_valid&!coeff_ready.
  - Handshake increments out_idx. Handshake at out_idx==31: if last block -> DONE, else block_cnt+1, elem_cnt=0 -> LOAD.
  - Pixels are not accepted during DRAIN (no overlap).
  - Throughput with no stalls: 64+SETTLE+32 cycles per block.
- DONE:
  - done=1, busy=0, coeff_valid=0.
  - start -> LOAD with block_cnt=0, done=0.
- abort (any state, sync) -> IDLE.
  - Counters cleared; coeff_valid drops next cycle; dp_original retained.
  - abort and start on the same edge: abort wins.
- coeff_data is the raw 64-bit buffer word; sign interpretation is downstream's.
- block_cnt wraps only via start; it never exceeds NUM_BLOCKS-1.

Decomposition:
- Package dct_pkg: ELEM_W, BLK_ELEMS=64, ZZ_ELEMS=32, NUM_BLOCKS, state encoding localparams (IDLE=0..DONE=4), element index widths.
- Sub-module dct_coeff_drain: 32-entry capture buffer + out_idx counter + valid/ready/last output mux.
- FSM, pixel loader and block counter stay in the top.

Test Plan:
1. Reset mid-LOAD, after 10 pixels -> all outputs 0, state IDLE. After release with no start, pix_ready stays 0.
2. Datapath stub C[l]=original[l]*2; NUM_BLOCKS=2; pixels 1..64 then 101..164; coeff_ready=1 -> first block outputs 2,4..64 with coeff_last on 64; second block outputs 202..264 with frame_last on 264; done=1. Block 0 latency: 64+2+32 cycles from start.
3. coeff_ready toggled 1-0-0-1 during DRAIN -> coeff_data constant through the 0 cycles; exactly 32 handshakes, no duplicates or drops.
4. pix_valid gaps (every 3rd cycle low) in LOAD -> SETTLE entered exactly one edge after the 64th accept; stub output unchanged.
5. abort asserted with start on the same edge, at out_idx=17 -> IDLE, coeff_valid=0 next cycle, done=0; a later start restarts at block 0.
6. start pulsed during SETTLE and DRAIN -> ignored, block_cnt unchanged; start in DONE -> new frame, done cleared next cycle.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared constants and state encoding for the DCT block sequencer and its drain buffer.
package dct_pkg;
    localparam int ELEM_W     = 64;
    localparam int BLK_ELEMS  = 64;
    localparam int ZZ_ELEMS   = 32;
    localparam int NUM_BLOCKS = 3072;
    localparam int SETTLE     = 2;

    localparam int ELEM_IDX_W = $clog2(BLK_ELEMS);
    localparam int BLK_CNT_W  = 12;
    localparam int SETTLE_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_e;
endpackage

// File: rtl/dct_coeff_drain.sv
// Snapshots the datapath's zigzag coefficients once per block and streams them
// out one element at a time under valid/ready.
module dct_coeff_drain #(
    parameter int ELEM_W   = 64,
    parameter int ZZ_ELEMS = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_i,
    input  logic                       capture_i,
    input  logic                       active_i,
    input  logic [ZZ_ELEMS*ELEM_W-1:0] coeff_i,
    input  logic                       ready_i,
    output logic [ELEM_W-1:0]          data_o,
    output logic                       valid_o,
    output logic                       last_o,
    output logic                       blk_done_o
);
    localparam int IDX_W = $clog2(ZZ_ELEMS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ZZ_ELEMS - 1);

    logic [ZZ_ELEMS-1:0][ELEM_W-1:0] cbuf_q;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic                            hs;

    assign valid_o    = active_i;
    assign last_o     = active_i && (idx_q == LAST_IDX);
    assign data_o     = active_i ? cbuf_q[idx_q] : '0;
    assign hs         = active_i && ready_i;
    assign blk_done_o = hs && last_o;

    always_comb begin
        idx_d = idx_q;
        if (clr_i || capture_i) begin
            idx_d = '0;
        end else if (hs) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cbuf_q <= '0;
            idx_q  <= '0;
        end else begin
            idx_q <= idx_d;
            if (capture_i) begin
                cbuf_q <= coeff_i;
            end
        end
    end
endmodule

// File: rtl/dct_block_sequencer.sv
// Frame sequencer for the combinational 8x8 DCT/quantise/zigzag datapath:
// loads 64 pixels, lets the datapath settle, then drains 32 coefficients per block.
module dct_block_sequencer #(
    parameter int ELEM_W     = dct_pkg::ELEM_W,
    parameter int NUM_BLOCKS = dct_pkg::NUM_BLOCKS,
    parameter int SETTLE     = dct_pkg::SETTLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ELEM_W-1:0]    pix_data,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    output logic [64*ELEM_W-1:0] dp_original,
    input  logic [32*ELEM_W-1:0] dp_coeff,
    output logic [ELEM_W-1:0]    coeff_data,
    output logic                 coeff_valid,
    input  logic                 coeff_ready,
    output logic                 coeff_last,
    output logic                 frame_last,
    output logic [11:0]          block_cnt,
    output logic                 busy,
    output logic                 done
);
    import dct_pkg::*;

    localparam logic [ELEM_IDX_W-1:0] LAST_ELEM   = ELEM_IDX_W'(BLK_ELEMS - 1);
    localparam logic [SETTLE_W-1:0]   LAST_SETTLE = SETTLE_W'(SETTLE - 1);
    localparam logic [BLK_CNT_W-1:0]  LAST_BLK    = BLK_CNT_W'(NUM_BLOCKS - 1);

    seq_state_e                       state_q, state_d;
    logic [ELEM_IDX_W-1:0]            elem_cnt_q, elem_cnt_d;
    logic [SETTLE_W-1:0]              settle_cnt_q, settle_cnt_d;
    logic [BLK_CNT_W-1:0]             block_cnt_q, block_cnt_d;
    logic [BLK_ELEMS-1:0][ELEM_W-1:0] orig_q;

    logic pix_wr;
    logic capture;
    logic blk_done;
    logic drain_last;

    assign pix_ready   = (state_q == ST_LOAD);
    assign busy        = (state_q == ST_LOAD) || (state_q == ST_SETTLE) || (state_q == ST_DRAIN);
    assign done        = (state_q == ST_DONE);
    assign block_cnt   = block_cnt_q;
    assign dp_original = orig_q;
    assign coeff_last  = drain_last;
    assign frame_last  = drain_last && (block_cnt_q == LAST_BLK);

    always_comb begin
        state_d      = state_q;
        elem_cnt_d   = elem_cnt_q;
        settle_cnt_d = settle_cnt_q;
        block_cnt_d  = block_cnt_q;
        capture      = 1'b0;
        pix_wr       = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    block_cnt_d = '0;
                    elem_cnt_d  = '0;
                end
            end
            ST_LOAD: begin
                if (pix_valid) begin
                    pix_wr     = 1'b1;
                    elem_cnt_d = elem_cnt_q + 1'b1;
                    if (elem_cnt_q == LAST_ELEM) begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = '0;
                    end
                end
            end
            ST_SETTLE: begin
                settle_cnt_d = settle_cnt_q + 1'b1;
                if (settle_cnt_q == LAST_SETTLE) begin
                    capture = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (blk_done) begin
                    if (block_cnt_q == LAST_BLK) begin
                        state_d = ST_DONE;
                    end else begin
                        block_cnt_d = block_cnt_q + 1'b1;
                        elem_cnt_d  = '0;
                        state_d     = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort beats everything, including a same-edge start; pixel memory is kept.
        if (abort) begin
            state_d      = ST_IDLE;
            elem_cnt_d   = '0;
            settle_cnt_d = '0;
            block_cnt_d  = '0;
            capture      = 1'b0;
            pix_wr       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            elem_cnt_q   <= '0;
            settle_cnt_q <= '0;
            block_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            elem_cnt_q   <= elem_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            block_cnt_q  <= block_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            orig_q <= '0;
        end else if (pix_wr) begin
            orig_q[elem_cnt_q] <= pix_data;
        end
    end

    dct_coeff_drain #(
        .ELEM_W   (ELEM_W),
        .ZZ_ELEMS (ZZ_ELEMS)
    ) u_drain (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (abort),
        .capture_i  (capture),
        .active_i   (state_q == ST_DRAIN),
        .coeff_i    (dp_coeff),
        .ready_i    (coeff_ready),
        .data_o     (coeff_data),
        .valid_o    (coeff_valid),
        .last_o     (drain_last),
        .blk_done_o (blk_done)
    );
endmodule

// File: tb/tb_dct_block_sequencer.sv
// Directed bench for dct_block_sequencer with a doubling datapath stub (C[l] = original[l]*2).
module tb_dct_block_sequencer;
    localparam int EW = 64;
    localparam int NB = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic pix_valid = 1'b0;
    logic coeff_ready = 1'b0;
    logic [EW-1:0] pix_data = '0;
    logic pix_ready, coeff_valid, coeff_last, frame_last, busy, done;
    logic [64*EW-1:0] dp_original;
    logic [32*EW-1:0] dp_coeff;
    logic [EW-1:0] coeff_data;
    logic [11:0] block_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int last_hs_cyc = 0;

    always #5 clk = ~clk;

    for (genvar l = 0; l < 32; l++) begin : g_stub
        assign dp_coeff[l*EW +: EW] = dp_original[l*EW +: EW] << 1;
    end

    dct_block_sequencer #(.ELEM_W(EW), .NUM_BLOCKS(NB), .SETTLE(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .dp_original(dp_original), .dp_coeff(dp_coeff),
        .coeff_data(coeff_data), .coeff_valid(coeff_valid), .coeff_ready(coeff_ready),
        .coeff_last(coeff_last), .frame_last(frame_last),
        .block_cnt(block_cnt), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
    endtask

    // Feed one block (pixels base+1..base+64), then drain stop_after coefficients.
    task automatic run_block(input int base, input bit gaps, input bit toggle,
                             input int stop_after, input bit poke, input bit exp_fl);
        int acc, c, k, n;
        bit stalled, hs;
        logic [63:0] held;
        acc = 0; c = 0;
        while (acc < 64 && c < 1000) begin
            pix_valid = !(gaps && (c % 3 == 2));
            pix_data  = 64'(base + acc + 1);
            if (pix_valid && pix_ready) acc++;
            tick();
            c++;
        end
        pix_valid = 1'b0;
        chk("load_accepts", 64'(acc), 64'd64);
        chk("settle_entry_ready", 64'(pix_ready), 64'd0);
        chk("settle_entry_busy", 64'(busy), 64'd1);
        chk("settle_entry_valid", 64'(coeff_valid), 64'd0);

        n = 0;
        start = poke;
        while (!coeff_valid && n < 100) begin
            tick();
            start = 1'b0;
            n++;
        end
        start = 1'b0;
        chk("settle_len", 64'(n), 64'd2);

        k = 0; c = 0; stalled = 0; held = '0;
        while (k < stop_after && c < 1000) begin
            coeff_ready = toggle ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            start = poke && (c == 2);
            if (stalled) begin
                chk("stall_valid", 64'(coeff_valid), 64'd1);
                chk("stall_hold", coeff_data, held);
            end
            hs = coeff_valid && coeff_ready;
            if (hs) begin
                chk("coeff", coeff_data, 64'(2 * (base + k + 1)));
                chk("coeff_last", 64'(coeff_last), 64'(k == 31));
                chk("frame_last", 64'(frame_last), 64'(exp_fl && k == 31));
                k++;
                stalled = 0;
            end else begin
                stalled = coeff_valid;
                held    = coeff_data;
            end
            tick();
            c++;
            if (hs) last_hs_cyc = cyc;
        end
        start = 1'b0;
        coeff_ready = 1'b0;
        chk("drain_count", 64'(k), 64'(stop_after));
    endtask

    initial begin
        // Reset state, then reset arriving mid-LOAD.
        #12;
        chk("rst_pix_ready", 64'(pix_ready), 64'd0);
        chk("rst_coeff_valid", 64'(coeff_valid), 64'd0);
        chk("rst_coeff_data", coeff_data, 64'd0);
        chk("rst_coeff_last", 64'(coeff_last), 64'd0);
        chk("rst_frame_last", 64'(frame_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_block_cnt", 64'(block_cnt), 64'd0);
        chk("rst_orig_zero", 64'(|dp_original), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            pix_valid = 1'b1;
            pix_data  = 64'(i + 1);
            tick();
        end
        chk("midload_busy", 64'(busy), 64'd1);
        chk("midload_orig_nz", 64'(|dp_original), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ready", 64'(pix_ready), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_orig", 64'(|dp_original), 64'd0);
        pix_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick(); tick(); tick();
        chk("idle_no_start_ready", 64'(pix_ready), 64'd0);
        chk("idle_no_start_busy", 64'(busy), 64'd0);
        chk("idle_no_start_done", 64'(done), 64'd0);

        // Full two-block frame with free-flowing output.
        pulse_start();
        chk("f1_block_cnt0", 64'(block_cnt), 64'd0);
        run_block(0, 0, 0, 32, 0, 0);
        chk("blk0_latency", 64'(last_hs_cyc - start_cyc), 64'd98);
        chk("f1_block_cnt1", 64'(block_cnt), 64'd1);
        chk("f1_back_to_load", 64'(pix_ready), 64'd1);
        run_block(100, 0, 0, 32, 0, 1);
        chk("f1_done", 64'(done), 64'd1);
        chk("f1_done_busy", 64'(busy), 64'd0);
        chk("f1_done_valid", 64'(coeff_valid), 64'd0);

        // Restart from DONE; gappy pixels, stalling sink, stray starts.
        pulse_start();
        chk("f2_done_cleared", 64'(done), 64'd0);
        chk("f2_busy", 64'(busy), 64'd1);
        chk("f2_block_cnt0", 64'(block_cnt), 64'd0);
        run_block(200, 1, 1, 32, 1, 0);
        chk("f2_block_cnt1", 64'(block_cnt), 64'd1);

        // Abort together with start mid-drain.
        run_block(300, 0, 0, 17, 0, 0);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_valid", 64'(coeff_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_block_cnt", 64'(block_cnt), 64'd0);
        chk("abort_ready", 64'(pix_ready), 64'd0);
        tick();
        chk("abort_stays_idle", 64'(pix_ready), 64'd0);

        pulse_start();
        chk("f3_block_cnt0", 64'(block_cnt), 64'd0);
        run_block(400, 0, 0, 32, 0, 0);
        chk("f3_block_cnt1", 64'(block_cnt), 64'd1);
        run_block(500, 0, 0, 32, 0, 1);
        chk("f3_done", 64'(done), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
